// File: rtl/mmul_pkg.sv
// Shared definitions for the MMUL block: sequencer state encoding and the
// derivations of the length-field width and the activation-to-result latency.
package mmul_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoadW,
    StStream,
    StDrain,
    StDone
  } state_e;

  // Width needed to hold a length or index in 0..k_max.
  function automatic int unsigned calc_kw(input int unsigned k_max);
    return $clog2(k_max + 1);
  endfunction

  // Skew buffer depth plus array traverse, both N deep.
  function automatic int unsigned calc_lat(input int unsigned n);
    return 2 * n;
  endfunction

endpackage

// File: rtl/valid_tag_pipe.sv
// Shift-on-enable bit pipe that mirrors the datapath pipeline. A 1 marks a
// real activation in flight, a 0 marks a bubble or drain vector.
//
// Ports:
//   clk        clock
//   reset      synchronous active-high reset, clears the pipe
//   en_i       advance the pipe by one stage
//   bit_i      tag shifted into stage 0 when en_i is high
//   msb_o      tag in the last stage (lines up with the array output)
//   any_next_o at least one tag is set in the value the pipe takes next
module valid_tag_pipe #(
  parameter int unsigned Depth = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  input  logic bit_i,
  output logic msb_o,
  output logic any_next_o
);

  logic [Depth-1:0] tag_q, tag_d;

  always_comb begin
    tag_d = tag_q;
    if (en_i) begin
      tag_d = {tag_q[Depth-2:0], bit_i};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tag_q <= '0;
    end else begin
      tag_q <= tag_d;
    end
  end

  assign msb_o      = tag_q[Depth-1];
  // Looks at the post-shift value so the drain can end in the same cycle the
  // last result leaves the array.
  assign any_next_o = |tag_d;

endmodule

// File: rtl/mmul_seq_ctrl.sv
// Job-level sequencer for the NxN weight-stationary systolic MMUL datapath.
// A job loads N weight rows, streams k_len activation vectors through the skew
// buffer, then drains the pipeline with zero vectors while tagging each result
// vector leaving the array with a valid flag and an index.
//
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   start_i, k_len_i             job request and its activation count (IDLE only)
//   busy_o, done_o               job in progress, one-cycle completion pulse
//   err_bad_len_o                one-cycle pulse after a rejected start
//   wt_valid_i / wt_ready_o      weight-row handshake
//   wt_load_o, wt_row_o          array weight-register load strobe and row index
//   act_valid_i / act_ready_o    activation-vector handshake
//   buf_enable_o, array_enable_o pipeline advance for skew buffer and array
//   act_zero_o                   force zero vectors into the buffer (drain)
//   res_valid_o, res_idx_o       result present at array output, and its index
module mmul_seq_ctrl
  import mmul_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned K_MAX = 64,
  parameter int unsigned LAT   = calc_lat(N),
  parameter int unsigned KW    = calc_kw(K_MAX)
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start_i,
  input  logic [KW-1:0]                        k_len_i,
  output logic                                 busy_o,
  output logic                                 done_o,
  output logic                                 err_bad_len_o,
  input  logic                                 wt_valid_i,
  output logic                                 wt_ready_o,
  output logic                                 wt_load_o,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] wt_row_o,
  input  logic                                 act_valid_i,
  output logic                                 act_ready_o,
  output logic                                 buf_enable_o,
  output logic                                 array_enable_o,
  output logic                                 act_zero_o,
  output logic                                 res_valid_o,
  output logic [KW-1:0]                        res_idx_o
);

  localparam int unsigned RW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] KMaxW = KW'(K_MAX);
  localparam logic [RW-1:0] LastRow = RW'(N - 1);

  state_e        state_q;
  logic [KW-1:0] k_len_q;
  logic [KW-1:0] act_cnt_q;
  logic [KW-1:0] res_idx_q;
  logic [RW-1:0] row_q;
  logic          err_q;

  logic adv;
  logic tag_msb;
  logic tag_any_next;
  logic len_bad;

  // Handshake readies come from state only, never from the valids.
  assign wt_ready_o    = (state_q == StLoadW);
  assign wt_load_o     = wt_ready_o & wt_valid_i;
  assign wt_row_o      = wt_load_o ? row_q : '0;
  assign act_ready_o   = (state_q == StStream);
  assign act_zero_o    = (state_q == StDrain);

  // A stream bubble freezes buffer, array and tag pipe together; the drain
  // advances every cycle.
  assign adv            = (act_ready_o & act_valid_i) | act_zero_o;
  assign buf_enable_o   = adv;
  assign array_enable_o = adv;

  assign res_valid_o   = adv & tag_msb;
  assign res_idx_o     = res_idx_q;
  assign busy_o        = (state_q != StIdle);
  assign done_o        = (state_q == StDone);
  assign err_bad_len_o = err_q;

  assign len_bad = (k_len_i == '0) || (k_len_i > KMaxW);

  valid_tag_pipe #(
    .Depth(LAT)
  ) u_tag_pipe (
    .clk       (clk),
    .reset     (reset),
    .en_i      (adv),
    .bit_i     (act_ready_o),
    .msb_o     (tag_msb),
    .any_next_o(tag_any_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      k_len_q   <= '0;
      act_cnt_q <= '0;
      res_idx_q <= '0;
      row_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (res_valid_o) begin
        res_idx_q <= res_idx_q + 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            if (len_bad) begin
              err_q <= 1'b1;
            end else begin
              k_len_q   <= k_len_i;
              act_cnt_q <= '0;
              res_idx_q <= '0;
              row_q     <= '0;
              state_q   <= StLoadW;
            end
          end
        end
        StLoadW: begin
          if (wt_load_o) begin
            row_q <= row_q + 1'b1;
            if (row_q == LastRow) begin
              state_q <= StStream;
            end
          end
        end
        StStream: begin
          if (act_valid_i) begin
            act_cnt_q <= act_cnt_q + 1'b1;
            if (act_cnt_q == k_len_q - 1'b1) begin
              state_q <= StDrain;
            end
          end
        end
        StDrain: begin
          if (!tag_any_next) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
